ascon_perm_scheduler: RTL

ASCON_PERM_SCHEDULER -- requirements
Module: ascon_perm_scheduler

---
 rtl/ascon_perm_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler: arbitrates two requesters (encrypt, decrypt) for a
// shared Ascon permutation datapath and sequences its round constants.
// A p12 request runs rounds 0..11, a p6 request runs rounds 6..11. Both are
// followed by a single DONE cycle that pulses done_o to the owner.
// Optional feature macro: ASCON_SCHED_RR_EN selects round-robin arbitration.
// Without it, requester 0 has fixed priority.
// Handshake: a requester holds req_i high until it is granted. Its grant_o
// bit marks ownership from the first RUN cycle through DONE. done_o is a
// single-cycle pulse. req_i is ignored everywhere except in IDLE.
module ascon_perm_scheduler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] p12_i,
  output logic [1:0] grant_o,
  output logic       perm_en_o,
  output logic [3:0] round_o,
  output logic       first_round_o,
  output logic       last_round_o,
  output logic [1:0] done_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [1:0] owner, owner_next;
  logic       p12_q, p12_next;
  logic [3:0] round_q, round_next;
  logic [1:0] pick;

`ifdef ASCON_SCHED_RR_EN
  // prio = 0 favours requester 0 on a tie, prio = 1 favours requester 1.
  logic prio, prio_next;

  // Round-robin pick: a tie goes to the requester not served last.
  always_comb begin
    pick = 2'b00;
    if (req_i == 2'b11) pick = prio ? 2'b10 : 2'b01;
    else if (req_i[0])  pick = 2'b01;
    else if (req_i[1])  pick = 2'b10;
  end

  // Pointer moves away from the owner once its permutation completes.
  always_comb begin
    prio_next = prio;
    if (state == DONE) prio_next = owner[0];
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prio <= 1'b0;
    else       prio <= prio_next;
  end
`else
  // Fixed priority pick: requester 0 always wins a tie.
  always_comb begin
    pick = 2'b00;
    if (req_i[0])      pick = 2'b01;
    else if (req_i[1]) pick = 2'b10;
  end
`endif

  // State, owner, round-count mode and round counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner   <= 2'b00;
      p12_q   <= 1'b0;
      round_q <= 4'd0;
    end else begin
      state   <= state_next;
      owner   <= owner_next;
      p12_q   <= p12_next;
      round_q <= round_next;
    end
  end

  // Next-state logic. The owner and mode are latched only in IDLE, so input
  // changes during RUN and DONE cannot disturb a running permutation.
  always_comb begin
    state_next = state;
    owner_next = owner;
    p12_next   = p12_q;
    round_next = round_q;
    case (state)
      IDLE: begin
        if (req_i != 2'b00) begin
          owner_next = pick;
          p12_next   = pick[0] ? p12_i[0] : p12_i[1];
          round_next = (pick[0] ? p12_i[0] : p12_i[1]) ? 4'd0 : 4'd6;
          state_next = RUN;
        end
      end
      RUN: begin
        if (round_q == 4'd11) begin
          state_next = DONE;
        end else begin
          round_next = round_q + 4'd1;
        end
      end
      DONE: begin
        round_next = 4'd0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the state alone. IDLE, and therefore reset,
  // drives every output to zero.
  always_comb begin
    grant_o       = 2'b00;
    perm_en_o     = 1'b0;
    round_o       = 4'd0;
    first_round_o = 1'b0;
    last_round_o  = 1'b0;
    done_o        = 2'b00;
    busy_o        = 1'b0;
    case (state)
      RUN: begin
        grant_o       = owner;
        perm_en_o     = 1'b1;
        round_o       = round_q;
        first_round_o = (round_q == (p12_q ? 4'd0 : 4'd6));
        last_round_o  = (round_q == 4'd11);
        busy_o        = 1'b1;
      end
      DONE: begin
        grant_o = owner;
        done_o  = owner;
        busy_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
